// File: rtl/int_vector_seq.sv
// Reset/interrupt sequencer for the 6502 core: runs the reset vector fetch, and for NMI, BRK or IRQ entry pushes PC and P, then loads the vector.
// Holds the memory bus while busy; done pulses for one cycle with the new PC, P and S.
module int_vector_seq #(
  parameter int unsigned ADDR_W       = 16,
  parameter logic [15:0] RESET_VEC    = 16'hFFFC,
  parameter logic [15:0] NMI_VEC      = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC_BASE = 16'hFFFE,
  parameter logic [15:0] IRQ_STRIDE   = 16'h0010,
  parameter int unsigned IRQ_LINES    = 1,
  parameter logic [15:0] STACK_BASE   = 16'h0100
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 nmi_n,
  input  logic [IRQ_LINES-1:0] irq,
  input  logic [IRQ_LINES-1:0] irq_mask,
  input  logic                 boundary,
  input  logic                 brk,
  input  logic [ADDR_W-1:0]    pc_in,
  input  logic [7:0]           p_in,
  input  logic [7:0]           s_in,
  input  logic [7:0]           rd_data,
  output logic [ADDR_W-1:0]    address,
  output logic [7:0]           wr_data,
  output logic                 wr_en,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    pc_out,
  output logic [7:0]           p_out,
  output logic [7:0]           s_out,
  output logic [1:0]           cause,
  output logic [2:0]           irq_id
);
  localparam int unsigned PC_BYTES = ADDR_W / 8;
  localparam logic [7:0]  LAST     = 8'(PC_BYTES - 1);
  localparam logic [7:0]  FRAME    = 8'(PC_BYTES + 1);

  typedef enum logic [2:0] {IDLE, RST_A, VEC_B, PUSH, PUSH_P, VEC_A, DONE} state_t;
  state_t state, state_nxt;

  logic [7:0]           cnt;
  logic [ADDR_W-1:0]    vec_addr, pc_sh, pc_acc, pc_acc_nxt;
  logic [7:0]           p_lat, s_lat, s_cur, push_p;
  logic                 nmi_n_q, nmi_pending;
  logic [IRQ_LINES-1:0] irq_act;
  logic                 irq_any, take_nmi, take_brk, take_irq, accept;
  logic [2:0]           irq_sel;

  function automatic logic [ADDR_W-1:0] irq_vec(input logic [2:0] k);
    logic [31:0] v;
    v = {16'h0, IRQ_VEC_BASE} - 32'(k) * {16'h0, IRQ_STRIDE};
    return ADDR_W'(v);
  endfunction

  // Lowest-numbered unmasked line wins.
  always_comb begin
    irq_act = irq & ~irq_mask;
    irq_any = |irq_act;
    irq_sel = 3'd0;
    for (int k = IRQ_LINES - 1; k >= 0; k--)
      if (irq_act[k]) irq_sel = 3'(k);
  end

  always_comb begin
    take_nmi = 1'b0;
    take_brk = 1'b0;
    take_irq = 1'b0;
    if (state == IDLE && boundary) begin
      if (nmi_pending)                take_nmi = 1'b1;
      else if (brk)                   take_brk = 1'b1;
      else if (irq_any && !p_in[2])   take_irq = 1'b1;
    end
    accept = take_nmi | take_brk | take_irq;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = PUSH;
      RST_A:   state_nxt = VEC_B;
      VEC_B:   if (cnt == LAST) state_nxt = DONE;
      PUSH:    if (cnt == LAST) state_nxt = PUSH_P;
      PUSH_P:  state_nxt = VEC_A;
      VEC_A:   state_nxt = VEC_B;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Vector bytes arrive LSB first, so each new byte enters at the top.
  always_comb begin
    pc_acc_nxt = pc_acc >> 8;
    pc_acc_nxt[ADDR_W-1 -: 8] = rd_data;
  end

  always_comb begin
    push_p  = ((p_lat | 8'h20) & 8'hEF) | ((cause == 2'd2) ? 8'h10 : 8'h00);
    address = vec_addr;
    wr_data = 8'h00;
    wr_en   = 1'b0;
    case (state)
      VEC_B:  address = vec_addr + ADDR_W'(cnt) + ADDR_W'(1);
      PUSH: begin
        address = ADDR_W'(STACK_BASE) + ADDR_W'(s_cur);
        wr_data = pc_sh[ADDR_W-1 -: 8];
        wr_en   = 1'b1;
      end
      PUSH_P: begin
        address = ADDR_W'(STACK_BASE) + ADDR_W'(s_cur);
        wr_data = push_p;
        wr_en   = 1'b1;
      end
      default: ;
    endcase
    busy = (state != IDLE) && (state != DONE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= RST_A;
      cnt         <= 8'd0;
      vec_addr    <= ADDR_W'(RESET_VEC);
      pc_sh       <= '0;
      pc_acc      <= '0;
      p_lat       <= 8'h00;
      s_lat       <= 8'h00;
      s_cur       <= 8'h00;
      pc_out      <= '0;
      p_out       <= 8'h24;
      s_out       <= 8'hFF;
      cause       <= 2'd0;
      irq_id      <= 3'd0;
      nmi_pending <= 1'b0;
      nmi_n_q     <= 1'b1;
    end else begin
      state       <= state_nxt;
      nmi_n_q     <= nmi_n;
      // A fresh edge in the accept cycle survives the clear.
      nmi_pending <= (nmi_pending && !take_nmi) || (nmi_n_q && !nmi_n);
      case (state)
        IDLE: if (accept) begin
          cnt      <= 8'd0;
          pc_sh    <= pc_in;
          p_lat    <= p_in;
          s_lat    <= s_in;
          s_cur    <= s_in;
          cause    <= take_nmi ? 2'd1 : (take_brk ? 2'd2 : 2'd3);
          irq_id   <= take_irq ? irq_sel : 3'd0;
          vec_addr <= take_nmi ? ADDR_W'(NMI_VEC) :
                      (take_brk ? ADDR_W'(IRQ_VEC_BASE) : irq_vec(irq_sel));
        end
        RST_A: cnt <= 8'd0;
        VEC_B: begin
          cnt    <= cnt + 8'd1;
          pc_acc <= pc_acc_nxt;
          if (cnt == LAST) begin
            pc_out <= pc_acc_nxt;
            p_out  <= (cause == 2'd0) ? 8'h24 : ((p_lat | 8'h04) & 8'hEF);
            s_out  <= (cause == 2'd0) ? 8'hFF : (s_lat - FRAME);
          end
        end
        PUSH: begin
          cnt   <= cnt + 8'd1;
          pc_sh <= pc_sh << 8;
          s_cur <= s_cur - 8'd1;
        end
        PUSH_P: s_cur <= s_cur - 8'd1;
        VEC_A:  cnt <= 8'd0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_int_vector_seq.sv
// Bench for int_vector_seq: a per-cycle expectation queue built from the entry rules checks every cycle,
// while directed scenarios pin the model with hand-computed literals before a randomized run.
`timescale 1ns/1ps
module tb_int_vector_seq;
  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0, nmi_n = 1'b1, boundary = 1'b0, brk = 1'b0;
  logic [NL-1:0] irq = '0, irq_mask = '0;
  logic [15:0]   pc_in = 16'h0;
  logic [7:0]    p_in = 8'h0, s_in = 8'h0, rd_data;
  logic [15:0]   address, pc_out;
  logic [7:0]    wr_data, p_out, s_out;
  logic          wr_en, busy, done;
  logic [1:0]    cause;
  logic [2:0]    irq_id;

  int errs = 0, checks = 0;
  logic [7:0] mem [0:65535];

  typedef struct packed {
    logic        busy, wr, chk_addr, done;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [15:0] pc;
    logic [7:0]  p, s;
    logic [1:0]  cause;
    logic [2:0]  id;
  } exp_t;

  exp_t q[$];
  bit   mpend = 1'b0, in_rst = 1'b1;
  logic mprev = 1'b1;

  int_vector_seq #(.ADDR_W(16), .RESET_VEC(16'hFFFC), .NMI_VEC(16'hFFFA), .IRQ_VEC_BASE(16'hFFFE),
                   .IRQ_STRIDE(16'h0010), .IRQ_LINES(NL), .STACK_BASE(16'h0100)) dut (
    .clk(clk), .resetn(resetn), .nmi_n(nmi_n), .irq(irq), .irq_mask(irq_mask),
    .boundary(boundary), .brk(brk), .pc_in(pc_in), .p_in(p_in), .s_in(s_in), .rd_data(rd_data),
    .address(address), .wr_data(wr_data), .wr_en(wr_en), .busy(busy), .done(done),
    .pc_out(pc_out), .p_out(p_out), .s_out(s_out), .cause(cause), .irq_id(irq_id));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Memory: read data valid one cycle after the address, writes land at the clock edge.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h80;
    mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h90;
    mem[16'hFFCE] = 8'h00; mem[16'hFFCF] = 8'hA3;
    mem[16'h017F] = 8'hEE; mem[16'h017E] = 8'hEE;
    rd_data = 8'h00;
    forever begin
      @(posedge clk);
      rd_data <= mem[address];
      if (wr_en) mem[address] <= wr_data;
    end
  end

  task automatic push_reset();
    exp_t e;
    e = '0; e.busy = 1'b1; e.chk_addr = 1'b1; e.addr = 16'hFFFC;
    q.push_back(e);
    e.chk_addr = 1'b0;
    q.push_back(e); q.push_back(e);
    e = '0; e.done = 1'b1; e.pc = {mem[16'hFFFD], mem[16'hFFFC]};
    e.p = 8'h24; e.s = 8'hFF; e.cause = 2'd0;
    q.push_back(e);
  endtask

  // Decide an entry from the current inputs and schedule the whole frame that must follow.
  task automatic model_accept();
    int k; logic [15:0] v; logic [1:0] c; exp_t e;
    k = -1;
    for (int i = NL - 1; i >= 0; i--) if (irq[i] && !irq_mask[i]) k = i;
    if (mpend) begin c = 2'd1; v = 16'hFFFA; mpend = 1'b0; end
    else if (brk) begin c = 2'd2; v = 16'hFFFE; end
    else if (k >= 0 && !p_in[2]) begin c = 2'd3; v = 16'(32'hFFFE - k * 16); end
    else return;
    for (int i = 0; i < 3; i++) begin
      e = '0; e.busy = 1'b1; e.wr = 1'b1; e.chk_addr = 1'b1;
      e.addr = 16'h0100 + {8'h00, 8'(s_in - 8'(i))};
      e.wd = (i == 0) ? pc_in[15:8] : (i == 1) ? pc_in[7:0]
           : (((p_in | 8'h20) & 8'hEF) | ((c == 2'd2) ? 8'h10 : 8'h00));
      q.push_back(e);
    end
    e = '0; e.busy = 1'b1; e.chk_addr = 1'b1; e.addr = v;
    q.push_back(e);
    e.chk_addr = 1'b0;
    q.push_back(e); q.push_back(e);
    e = '0; e.done = 1'b1; e.pc = {mem[v + 16'd1], mem[v]};
    e.p = (p_in | 8'h04) & 8'hEF; e.s = s_in - 8'd3; e.cause = c;
    e.id = (c == 2'd3) ? 3'(k) : 3'd0;
    q.push_back(e);
  endtask

  // One compare process: every cycle, DUT outputs against the model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        chk("rst_busy", busy, 1); chk("rst_wr_en", wr_en, 0); chk("rst_done", done, 0);
        chk("rst_addr", address, 16'hFFFC); chk("rst_pc", pc_out, 0);
        chk("rst_p", p_out, 8'h24); chk("rst_s", s_out, 8'hFF); chk("rst_cause", cause, 0);
        q.delete(); mpend = 1'b0; mprev = 1'b1; in_rst = 1'b1;
      end else begin
        if (in_rst) begin in_rst = 1'b0; push_reset(); end
        if (q.size() == 0) begin
          chk("idle_busy", busy, 0); chk("idle_wr_en", wr_en, 0); chk("idle_done", done, 0);
          if (boundary) model_accept();
        end else begin
          e = q.pop_front();
          chk("busy", busy, e.busy); chk("wr_en", wr_en, e.wr); chk("done", done, e.done);
          if (e.chk_addr) chk("address", address, e.addr);
          if (e.wr) chk("wr_data", wr_data, e.wd);
          if (e.done) begin
            chk("pc_out", pc_out, e.pc); chk("p_out", p_out, e.p);
            chk("s_out", s_out, e.s); chk("cause", cause, e.cause);
            if (e.cause == 2'd3) chk("irq_id", irq_id, e.id);
          end
        end
        if (mprev && !nmi_n) mpend = 1'b1;
        mprev = nmi_n;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin n = i; break; end
    end
    chk("done_timeout", (n != 0), 1);
  endtask

  initial begin
    int n, rst_cnt;
    // Reset vector fetch
    repeat (3) tick();
    resetn = 1'b1;
    wait_done(n);
    chk("L_rst_latency", n, 4); chk("L_rst_pc", pc_out, 16'h1234);
    chk("L_rst_p", p_out, 8'h24); chk("L_rst_s", s_out, 8'hFF); chk("L_rst_cause", cause, 0);
    tick(); tick();

    // IRQ line 0 entry
    irq = 4'b0001; p_in = 8'h20; pc_in = 16'hC123; s_in = 8'hFF; boundary = 1'b1;
    tick();
    boundary = 1'b0; irq = '0;
    wait_done(n);
    chk("L_irq_latency", n, 7); chk("L_irq_pc", pc_out, 16'h8000); chk("L_irq_p", p_out, 8'h24);
    chk("L_irq_s", s_out, 8'hFC); chk("L_irq_cause", cause, 3);
    chk("L_irq_m1FF", mem[16'h01FF], 8'hC1); chk("L_irq_m1FE", mem[16'h01FE], 8'h23);
    chk("L_irq_m1FD", mem[16'h01FD], 8'h20);
    tick();

    // BRK with stack wrap
    brk = 1'b1; s_in = 8'h01; pc_in = 16'h4567; p_in = 8'h00; boundary = 1'b1;
    tick();
    boundary = 1'b0; brk = 1'b0;
    wait_done(n);
    chk("L_brk_s", s_out, 8'hFE); chk("L_brk_cause", cause, 2); chk("L_brk_p", p_out, 8'h04);
    chk("L_brk_m101", mem[16'h0101], 8'h45); chk("L_brk_m100", mem[16'h0100], 8'h67);
    chk("L_brk_m1FF", mem[16'h01FF], 8'h30);
    tick();

    // NMI beats BRK and IRQ at the same boundary
    nmi_n = 1'b0;
    tick();
    irq = 4'b0001; brk = 1'b1; boundary = 1'b1; pc_in = 16'h2222; s_in = 8'hF0; p_in = 8'h00;
    tick();
    boundary = 1'b0; brk = 1'b0; irq = '0; nmi_n = 1'b1;
    wait_done(n);
    chk("L_nmi_cause", cause, 1); chk("L_nmi_pc", pc_out, 16'h9000); chk("L_nmi_s", s_out, 8'hED);
    tick();

    // BRK next, with an NMI edge arriving during its push
    brk = 1'b1; boundary = 1'b1; pc_in = 16'h3333; s_in = 8'hE0;
    tick();
    boundary = 1'b0; brk = 1'b0;
    tick();
    nmi_n = 1'b0;
    tick();
    nmi_n = 1'b1;
    wait_done(n);
    chk("L_brk2_cause", cause, 2);
    tick();
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    wait_done(n);
    chk("L_nmi2_cause", cause, 1);
    tick();

    // Multi-line IRQ with mask
    irq = 4'b1100; irq_mask = 4'b0100; p_in = 8'h00; s_in = 8'h90; boundary = 1'b1;
    tick();
    boundary = 1'b0;
    wait_done(n);
    chk("L_irq3_cause", cause, 3); chk("L_irq3_id", irq_id, 3); chk("L_irq3_pc", pc_out, 16'hA300);
    tick();
    p_in = 8'h04; boundary = 1'b1;
    tick();
    boundary = 1'b0;
    @(negedge clk);
    chk("L_irq_I_set_busy", busy, 0);
    tick();
    irq = '0; irq_mask = '0; p_in = 8'h00;

    // Reset in the middle of a push
    brk = 1'b1; pc_in = 16'hABCD; s_in = 8'h80; boundary = 1'b1;
    tick();
    boundary = 1'b0; brk = 1'b0;
    tick();
    resetn = 1'b0;
    #1 chk("L_abort_wr_en", wr_en, 0);
    tick(); tick();
    chk("L_abort_m180", mem[16'h0180], 8'hAB);
    chk("L_abort_m17F", mem[16'h017F], 8'hEE);
    chk("L_abort_m17E", mem[16'h017E], 8'hEE);
    resetn = 1'b1;
    wait_done(n);
    chk("L_rerun_latency", n, 4); chk("L_rerun_pc", pc_out, 16'h1234); chk("L_rerun_cause", cause, 0);
    chk("L_rerun_m17F", mem[16'h017F], 8'hEE);
    tick();

    // Randomized traffic
    rst_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      boundary = ($urandom_range(0, 3) == 0);
      brk      = ($urandom_range(0, 3) == 0);
      irq      = NL'($urandom) & NL'($urandom);
      irq_mask = NL'($urandom);
      p_in     = 8'($urandom);
      pc_in    = 16'($urandom);
      s_in     = 8'($urandom);
      if ($urandom_range(0, 9) == 0) nmi_n = ~nmi_n;
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) resetn = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        resetn = 1'b0; rst_cnt = 2;
      end
      tick();
    end
    resetn = 1'b1; boundary = 1'b0; brk = 1'b0; irq = '0;
    repeat (15) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
